// File: rtl/pass_scheduler.sv
// Layer-level sequencer: runs the per-pass controller once per (m, c) tile pair, m outer, c inner.
// Optional busy-cycle counter built only when PASS_SCHED_PERF_EN is defined.
module pass_scheduler #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       op_config_in,
  input  logic [31:0]       mapping_param_in,
  input  logic [31:0]       shape_param1_in,
  input  logic [31:0]       shape_param2_in,
  input  logic [ADDR_W-1:0] filter_base_in,
  input  logic [ADDR_W-1:0] ifmap_base_in,
  input  logic [ADDR_W-1:0] bias_base_in,
  input  logic [ADDR_W-1:0] opsum_base_in,
  input  logic [ADDR_W-1:0] filter_stride,
  input  logic [ADDR_W-1:0] ifmap_stride,
  input  logic [ADDR_W-1:0] bias_stride,
  input  logic [ADDR_W-1:0] opsum_stride,
  input  logic [CNT_W-1:0]  num_m_tiles,
  input  logic [CNT_W-1:0]  num_c_tiles,
  input  logic              pass_done,
  output logic [31:0]       op_config,
  output logic [31:0]       mapping_param,
  output logic [31:0]       shape_param1,
  output logic [31:0]       shape_param2,
  output logic [ADDR_W-1:0] filter_baseaddr,
  output logic [ADDR_W-1:0] ifmap_baseaddr,
  output logic [ADDR_W-1:0] bias_baseaddr,
  output logic [ADDR_W-1:0] opsum_baseaddr,
  output logic              bias_ipsum_sel,
  output logic              busy,
  output logic              layer_done,
  output logic [CNT_W-1:0]  m_idx,
  output logic [CNT_W-1:0]  c_idx,
  output logic [31:0]       perf_cycles,
  output logic [2:0]        dbg_state_o
);

  // Handshake: start is accepted only in IDLE, pass_done only in WAIT; op_config[0]
  // is a one-cycle launch strobe and layer_done a one-cycle completion strobe.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_ADVANCE, S_FINISH
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       op_cfg_q, map_q, shp1_q, shp2_q;
  logic [ADDR_W-1:0] ifmap_base_q;
  logic [ADDR_W-1:0] fstride_q, istride_q, bstride_q, ostride_q;
  logic [CNT_W-1:0]  num_m_q, num_c_q;
  logic [CNT_W-1:0]  m_q, m_d, c_q, c_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d, iaddr_q, iaddr_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d, oaddr_q, oaddr_d;
  logic              accept;

  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    c_d     = c_q;
    faddr_d = faddr_q;
    iaddr_d = iaddr_q;
    baddr_d = baddr_q;
    oaddr_d = oaddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          m_d     = '0;
          c_d     = '0;
          faddr_d = filter_base_in;
          iaddr_d = ifmap_base_in;
          baddr_d = bias_base_in;
          oaddr_d = opsum_base_in;
        end
      end
      S_LOAD:   state_d = (num_m_q == '0 || num_c_q == '0) ? S_FINISH : S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (pass_done) state_d = S_ADVANCE;
      S_ADVANCE: begin
        // Running sums replace the m*C+c products of the address equations.
        faddr_d = faddr_q + fstride_q;
        if (c_q < num_c_q - CNT_W'(1)) begin
          c_d     = c_q + CNT_W'(1);
          iaddr_d = iaddr_q + istride_q;
          state_d = S_LAUNCH;
        end else if (m_q < num_m_q - CNT_W'(1)) begin
          c_d     = '0;
          m_d     = m_q + CNT_W'(1);
          iaddr_d = ifmap_base_q;
          baddr_d = baddr_q + bstride_q;
          oaddr_d = oaddr_q + ostride_q;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_cfg_q     <= '0;
      map_q        <= '0;
      shp1_q       <= '0;
      shp2_q       <= '0;
      ifmap_base_q <= '0;
      fstride_q    <= '0;
      istride_q    <= '0;
      bstride_q    <= '0;
      ostride_q    <= '0;
      num_m_q      <= '0;
      num_c_q      <= '0;
      m_q          <= '0;
      c_q          <= '0;
      faddr_q      <= '0;
      iaddr_q      <= '0;
      baddr_q      <= '0;
      oaddr_q      <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      c_q     <= c_d;
      faddr_q <= faddr_d;
      iaddr_q <= iaddr_d;
      baddr_q <= baddr_d;
      oaddr_q <= oaddr_d;
      if (accept) begin
        op_cfg_q     <= op_config_in;
        map_q        <= mapping_param_in;
        shp1_q       <= shape_param1_in;
        shp2_q       <= shape_param2_in;
        ifmap_base_q <= ifmap_base_in;
        fstride_q    <= filter_stride;
        istride_q    <= ifmap_stride;
        bstride_q    <= bias_stride;
        ostride_q    <= opsum_stride;
        num_m_q      <= num_m_tiles;
        num_c_q      <= num_c_tiles;
      end
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign layer_done      = (state_q == S_FINISH);
  // Bit 0 carries only the launch strobe so the pass controller cannot re-trigger itself.
  assign op_config       = (op_cfg_q & 32'hFFFF_FFFE) | {31'd0, state_q == S_LAUNCH};
  assign mapping_param   = map_q;
  assign shape_param1    = shp1_q;
  assign shape_param2    = shp2_q;
  assign filter_baseaddr = faddr_q;
  assign ifmap_baseaddr  = iaddr_q;
  assign bias_baseaddr   = baddr_q;
  assign opsum_baseaddr  = oaddr_q;
  assign bias_ipsum_sel  = (c_q == '0);
  assign m_idx           = m_q;
  assign c_idx           = c_q;
  assign dbg_state_o     = state_q;

`ifdef PASS_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept) begin
      perf_d = '0;
    end else if (busy && perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
